// File: rtl/dcsk_pkg.sv
// Shared types and defaults for the DCSK transmit/receive blocks.
package dcsk_pkg;

    localparam int MSG_W_DEF = 32;
    localparam int SF_W_DEF  = 5;

    typedef enum logic [1:0] {
        IDLE,
        REF,
        DATA,
        DONE
    } rx_state_e;

    // Correlation step for one data chip: +1 when it matches its reference chip, -1 otherwise.
    function automatic int chip_sign(input logic chip, input logic ref_chip);
        return (chip ~^ ref_chip) ? 1 : -1;
    endfunction

endpackage

// File: rtl/dcsk_rx_demod_sipo.sv
// Serial-in/parallel-out message assembler, MSB-first; counterpart of the tx piso buffer.
module dcsk_rx_demod_sipo #(
    parameter int MSG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [MSG_W-1:0] next_word
);

    logic [MSG_W-1:0] word;

    // Word as it will look once the current bit is shifted in, so the top can capture it on the same edge.
    assign next_word = (word << 1) | MSG_W'(bit_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
        end else if (clear) begin
            word <= '0;
        end else if (shift_en) begin
            word <= next_word;
        end
    end

endmodule

// File: rtl/dcsk_rx_demod.sv
// DCSK receiver: correlates each data half against its reference half and assembles the decided bits.
// Optional correlator debug outputs (o_corr, o_corr_valid) are enabled by defining DCSK_RX_CORR_OUT_EN.
module dcsk_rx_demod
    import dcsk_pkg::*;
#(
    parameter int MSG_W = MSG_W_DEF,
    parameter int SF_W  = SF_W_DEF,
    parameter int ACC_W = SF_W + 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_chip,
    input  logic                    i_chip_en,
    input  logic [SF_W-1:0]         i_sf,
    output logic                    o_busy,
    output logic [MSG_W-1:0]        o_msg,
    output logic                    o_msg_valid
`ifdef DCSK_RX_CORR_OUT_EN
    ,
    output logic signed [ACC_W-1:0] o_corr,
    output logic                    o_corr_valid
`endif
);

    localparam int BIT_W = $clog2(MSG_W);
    localparam int REF_N = 1 << SF_W;

    rx_state_e state, state_next;

    logic [SF_W-1:0]         sf_q;
    logic [SF_W-1:0]         sf_start;
    logic [SF_W-1:0]         chip_ctr;
    logic [BIT_W-1:0]        bit_ctr;
    logic [REF_N-1:0]        ref_buf;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    accept;
    logic                    decide;
    logic                    last_chip;
    logic                    last_bit;
    logic                    bit_val;
    logic [MSG_W-1:0]        msg_next;

    assign sf_start  = (i_sf == '0) ? SF_W'(1) : i_sf;
    assign last_chip = (chip_ctr == sf_q - SF_W'(1));
    assign last_bit  = (bit_ctr == BIT_W'(MSG_W - 1));
    assign acc_sum   = acc + ACC_W'(chip_sign(i_chip, ref_buf[chip_ctr]));
    // A zero sum (tie) decides 1.
    assign bit_val   = ~acc_sum[ACC_W-1];
    assign o_busy    = (state != IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        decide     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start && i_chip_en) begin
                    accept     = 1'b1;
                    state_next = (sf_start == SF_W'(1)) ? DATA : REF;
                end
            end
            REF: begin
                if (i_chip_en && last_chip) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (i_chip_en && last_chip) begin
                    decide     = 1'b1;
                    state_next = last_bit ? DONE : REF;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Reference capture, correlation and bit counting; o_msg is loaded on the final decision edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sf_q        <= '0;
            chip_ctr    <= '0;
            bit_ctr     <= '0;
            ref_buf     <= '0;
            acc         <= '0;
            o_msg       <= '0;
            o_msg_valid <= 1'b0;
        end else begin
            o_msg_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sf_q       <= sf_start;
                        ref_buf[0] <= i_chip;
                        chip_ctr   <= (sf_start == SF_W'(1)) ? SF_W'(0) : SF_W'(1);
                        bit_ctr    <= '0;
                        acc        <= '0;
                    end
                end
                REF: begin
                    if (i_chip_en) begin
                        ref_buf[chip_ctr] <= i_chip;
                        if (last_chip) begin
                            chip_ctr <= '0;
                            acc      <= '0;
                        end else begin
                            chip_ctr <= chip_ctr + SF_W'(1);
                        end
                    end
                end
                DATA: begin
                    if (decide) begin
                        chip_ctr <= '0;
                        acc      <= '0;
                        if (last_bit) begin
                            o_msg       <= msg_next;
                            o_msg_valid <= 1'b1;
                        end else begin
                            bit_ctr <= bit_ctr + BIT_W'(1);
                        end
                    end else if (i_chip_en) begin
                        acc      <= acc_sum;
                        chip_ctr <= chip_ctr + SF_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    dcsk_rx_demod_sipo #(
        .MSG_W(MSG_W)
    ) u_sipo (
        .clk      (i_clk),
        .rst      (i_rst),
        .clear    (accept),
        .shift_en (decide),
        .bit_in   (bit_val),
        .next_word(msg_next)
    );

`ifdef DCSK_RX_CORR_OUT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_corr       <= '0;
            o_corr_valid <= 1'b0;
        end else begin
            o_corr_valid <= decide;
            if (decide) begin
                o_corr <= acc_sum;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dcsk_rx_demod.sv
// Bench for dcsk_rx_demod: a DCSK chip generator drives packets from a vector table; a scoreboard checks o_msg.
module tb_dcsk_rx_demod;

    localparam int MSG_W = 32;
    localparam int SF_W  = 5;
    localparam int ACC_W = SF_W + 1;
    localparam int NVEC  = 9;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    chip;
    logic                    chip_en;
    logic [SF_W-1:0]         sf;
    logic                    busy;
    logic [MSG_W-1:0]        msg;
    logic                    msg_valid;
`ifdef DCSK_RX_CORR_OUT_EN
    logic signed [ACC_W-1:0] corr;
    logic                    corr_valid;
`endif

    always #5 clk = ~clk;

    dcsk_rx_demod #(
        .MSG_W(MSG_W),
        .SF_W (SF_W),
        .ACC_W(ACC_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_chip      (chip),
        .i_chip_en   (chip_en),
        .i_sf        (sf),
        .o_busy      (busy),
        .o_msg       (msg),
        .o_msg_valid (msg_valid)
`ifdef DCSK_RX_CORR_OUT_EN
        ,
        .o_corr      (corr),
        .o_corr_valid(corr_valid)
`endif
    );

    typedef struct {
        logic [SF_W-1:0]  sf;
        logic [MSG_W-1:0] msg;
        int               flip_n;
        logic [MSG_W-1:0] flip_mask;
        int               en_pct;
        bit               inject_start;
        bit               tie;
        logic [MSG_W-1:0] exp_msg;
    } vec_t;

    vec_t             vecs[NVEC];
    logic [MSG_W-1:0] exp_q[$];
    int               checks = 0;
    int               errors = 0;
    int               busy_cycles = 0;
    int               valid_pulses = 0;
    bit               tie_mode = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Scoreboard: every valid pulse must match the oldest expected message.
    always @(negedge clk) begin
        if (busy) busy_cycles++;
        if (msg_valid) begin
            valid_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got msg %h, expected no pulse", msg);
            end else begin
                checkOutput("msg", msg, exp_q.pop_front());
            end
        end
    end

`ifdef DCSK_RX_CORR_OUT_EN
    always @(negedge clk) begin
        if (corr_valid && tie_mode) checkOutput("tie_corr", 32'(corr), 32'd0);
    end
`endif

    task automatic driveChip(input logic c, input logic st, input int en_pct, input bit inj);
        while ($urandom_range(0, 99) >= en_pct) begin
            chip_en = 1'b0;
            start   = 1'b0;
            chip    = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chip    = c;
        chip_en = 1'b1;
        start   = st | (inj && ($urandom_range(0, 3) == 0));
        if (inj && !st) sf = SF_W'($urandom_range(0, 31));
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v, input int abort_bit);
        int   eff;
        logic ref_chips[32];
        logic c;
        bit   first;
        eff      = (v.sf == '0) ? 1 : int'(v.sf);
        first    = 1'b1;
        tie_mode = v.tie;
        if (abort_bit < 0) exp_q.push_back(v.exp_msg);
        sf          = v.sf;
        busy_cycles = 0;
        for (int b = MSG_W - 1; b >= 0; b--) begin
            for (int k = 0; k < eff; k++) ref_chips[k] = 1'($urandom_range(0, 1));
            for (int k = 0; k < eff; k++) begin
                driveChip(ref_chips[k], first, v.en_pct, v.inject_start);
                first = 1'b0;
            end
            if (abort_bit == MSG_W - 1 - b) begin
                rst     = 1'b1;
                chip_en = 1'b0;
                start   = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                checkOutput("abort_busy", 32'(busy), 32'd0);
                checkOutput("abort_msg", msg, 32'd0);
                checkOutput("abort_valid", 32'(msg_valid), 32'd0);
                return;
            end
            for (int k = 0; k < eff; k++) begin
                c = v.msg[b] ? ref_chips[k] : ~ref_chips[k];
                if (v.flip_mask[b] && k < v.flip_n) c = ~c;
                driveChip(c, 1'b0, v.en_pct, v.inject_start);
            end
        end
        chip_en = 1'b0;
        start   = 1'b0;
        checkOutput("valid_latency", 32'(msg_valid), 32'd1);
        @(negedge clk);
        #1;
        checkOutput("busy_done", 32'(busy), 32'd0);
        if (v.en_pct == 100) checkOutput("busy_cycles", busy_cycles, 2 * eff * MSG_W);
        repeat (2) @(negedge clk);
        checkOutput("msg_hold", msg, v.exp_msg);
        checkOutput("valid_low", 32'(msg_valid), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t abort_v;
        vec_t after_v;
        rst     = 1'b1;
        start   = 1'b0;
        chip    = 1'b0;
        chip_en = 1'b0;
        sf      = '0;

        vecs[0] = '{5'd8,  32'hA5A5_0F0F, 0, 32'h0000_0000, 100, 1'b0, 1'b0, 32'hA5A5_0F0F};
        vecs[1] = '{5'd1,  32'hFFFF_FFFF, 0, 32'h0000_0000, 100, 1'b0, 1'b0, 32'hFFFF_FFFF};
        vecs[2] = '{5'd31, 32'h0000_0001, 0, 32'h0000_0000, 100, 1'b0, 1'b0, 32'h0000_0001};
        vecs[3] = '{5'd0,  32'h1234_5678, 0, 32'h0000_0000, 100, 1'b0, 1'b0, 32'h1234_5678};
        vecs[4] = '{5'd4,  32'h0F0F_0F0F, 2, 32'hFFFF_FFFF, 100, 1'b0, 1'b1, 32'hFFFF_FFFF};
        vecs[5] = '{5'd7,  32'hC3C3_5A5A, 3, 32'hFFFF_FFFF, 100, 1'b0, 1'b0, 32'hC3C3_5A5A};
        vecs[6] = '{5'd7,  32'hC3C3_5A5A, 4, 32'h0001_0000, 100, 1'b0, 1'b0, 32'hC3C2_5A5A};
        vecs[7] = '{5'd8,  32'hA5A5_0F0F, 0, 32'h0000_0000, 50,  1'b0, 1'b0, 32'hA5A5_0F0F};
        vecs[8] = '{5'd5,  32'hDEAD_BEEF, 0, 32'h0000_0000, 100, 1'b1, 1'b0, 32'hDEAD_BEEF};
        abort_v = '{5'd6,  32'h5555_AAAA, 0, 32'h0000_0000, 100, 1'b0, 1'b0, 32'h5555_AAAA};
        after_v = '{5'd3,  32'h0BAD_F00D, 0, 32'h0000_0000, 100, 1'b0, 1'b0, 32'h0BAD_F00D};

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_msg", msg, 32'd0);
        checkOutput("reset_valid", 32'(msg_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            $display("[TB] vector %0d: sf=%0d msg=%h", i, vecs[i].sf, vecs[i].msg);
            applyStimulus(vecs[i], -1);
        end

        $display("[TB] reset at bit 10 of a packet, then a fresh packet");
        applyStimulus(abort_v, 10);
        repeat (2) @(negedge clk);
        applyStimulus(after_v, -1);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        checkOutput("valid_pulses", valid_pulses, NVEC + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
